booth_product_fifo: RTL and testbench

Output-side buffer for the 16x16 Booth multiplier. It captures the 32-bit product `{A,Q}` from the datapath on the controller's completion pulse and queues it in a small first-word-fall-through FIFO. Products leave the FIFO over a valid/ready handshake. The block sits directly downstream of the Booth datapath and controller, and asserts `hold` so the controller does not start a multiplication whose result cannot be stored.

---
 rtl/booth_pkg.sv | 7 +
 rtl/booth_fifo_mem.sv | 26 ++
 rtl/booth_product_fifo.sv | 98 +++++++++
 tb/tb_booth_product_fifo.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared widths and product type for the Booth multiplier output path.
package booth_pkg;
    localparam int HALF_W = 16;
    localparam int PROD_W = 32;

    typedef logic [PROD_W-1:0] product_t;
endpackage

// File: rtl/booth_fifo_mem.sv
// Product storage for the output FIFO: synchronous write, combinational read.
module booth_fifo_mem
    import booth_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  product_t      wdata_i,
    input  logic [AW-1:0] raddr_i,
    output product_t      rdata_o
);

    product_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/booth_product_fifo.sv
// First-word-fall-through queue of Booth products with a valid/ready drain
// and a hold signal back to the controller.
module booth_product_fifo
    import booth_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              done_in,
    input  logic [HALF_W-1:0] A_in,
    input  logic [HALF_W-1:0] Q_in,
    output logic              out_valid,
    input  logic              out_ready,
    output product_t          out_product,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count,
    output logic              hold,
    output logic              overflow,
    input  logic              clr_ovf
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;

    logic     push, pop, drop;
    product_t rd_data;

    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign hold      = full;
    assign count     = count_q;
    assign overflow  = ovf_q;
    assign out_valid = ~empty;
    assign out_product = empty ? '0 : rd_data;

    // A pop frees the slot the simultaneous push lands in, so full still accepts.
    assign pop  = out_valid & out_ready;
    assign push = done_in & (~full | pop);
    assign drop = done_in & full & ~pop;

    booth_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (PTR_W)
    ) u_mem (
        .clk     (clk),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i ({A_in, Q_in}),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_data)
    );

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

endmodule

// File: tb/tb_booth_product_fifo.sv
// Directed bench: DEPTH=4 instance for most scenarios, DEPTH=3 for wrap.
module tb_booth_product_fifo;
    import booth_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total = 0;

    logic              a_done = 1'b0, a_ready = 1'b0, a_clr = 1'b0;
    logic [HALF_W-1:0] a_A = '0, a_Q = '0;
    logic              a_valid, a_full, a_empty, a_hold, a_ovf;
    product_t          a_prod;
    logic [2:0]        a_count;

    logic              b_done = 1'b0, b_ready = 1'b0, b_clr = 1'b0;
    logic [HALF_W-1:0] b_A = '0, b_Q = '0;
    logic              b_valid, b_full, b_empty, b_hold, b_ovf;
    product_t          b_prod;
    logic [1:0]        b_count;

    booth_product_fifo #(.DEPTH(4)) dut_a (
        .clk(clk), .rst(rst), .done_in(a_done), .A_in(a_A), .Q_in(a_Q),
        .out_valid(a_valid), .out_ready(a_ready), .out_product(a_prod),
        .full(a_full), .empty(a_empty), .count(a_count), .hold(a_hold),
        .overflow(a_ovf), .clr_ovf(a_clr)
    );

    booth_product_fifo #(.DEPTH(3)) dut_b (
        .clk(clk), .rst(rst), .done_in(b_done), .A_in(b_A), .Q_in(b_Q),
        .out_valid(b_valid), .out_ready(b_ready), .out_product(b_prod),
        .full(b_full), .empty(b_empty), .count(b_count), .hold(b_hold),
        .overflow(b_ovf), .clr_ovf(b_clr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_push(input logic [31:0] w);
        {a_A, a_Q} = w;
        a_done = 1'b1;
        tick();
        a_done = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        total++;
        if ({a_count, a_empty, a_full, a_hold, a_valid, a_ovf} !== 8'b000_10000)
            $display("FAIL reset_flags got cnt=%0d e=%b f=%b h=%b v=%b o=%b want 0 1 0 0 0 0",
                     a_count, a_empty, a_full, a_hold, a_valid, a_ovf);
        else pass_cnt++;
        total++;
        if (a_prod !== 32'h0)
            $display("FAIL reset_product got %h want 00000000", a_prod);
        else pass_cnt++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        {a_A, a_Q} = {16'hFFFF, 16'hFFF1};
        a_done = 1'b1;
        #1;
        total++;
        if (a_valid !== 1'b0)
            $display("FAIL no_bypass got valid=%b want 0", a_valid);
        else pass_cnt++;
        tick();
        a_done = 1'b0;
        total++;
        if (a_valid !== 1'b1 || a_prod !== 32'hFFFFFFF1 || a_count !== 3'd1)
            $display("FAIL single_push got v=%b p=%h c=%0d want 1 fffffff1 1",
                     a_valid, a_prod, a_count);
        else pass_cnt++;
        a_ready = 1'b1;
        tick();
        a_ready = 1'b0;
        total++;
        if (a_empty !== 1'b1 || a_prod !== 32'h0 || a_valid !== 1'b0)
            $display("FAIL single_pop got e=%b p=%h v=%b want 1 00000000 0",
                     a_empty, a_prod, a_valid);
        else pass_cnt++;
    endtask

    task automatic test_fill_overflow();
        for (int i = 1; i <= 4; i++) a_push(32'(i));
        total++;
        if (a_full !== 1'b1 || a_hold !== 1'b1 || a_count !== 3'd4)
            $display("FAIL fill_full got f=%b h=%b c=%0d want 1 1 4", a_full, a_hold, a_count);
        else pass_cnt++;
        a_push(32'd5);
        total++;
        if (a_ovf !== 1'b1 || a_count !== 3'd4)
            $display("FAIL fill_drop got o=%b c=%0d want 1 4", a_ovf, a_count);
        else pass_cnt++;
        tick();
        total++;
        if (a_prod !== 32'd1)
            $display("FAIL hold_stable got %h want 00000001", a_prod);
        else pass_cnt++;
        a_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            total++;
            if (a_prod !== 32'(i))
                $display("FAIL fill_drain%0d got %h want %h", i, a_prod, 32'(i));
            else pass_cnt++;
            tick();
        end
        a_ready = 1'b0;
        total++;
        if (a_empty !== 1'b1)
            $display("FAIL fill_empty got %b want 1", a_empty);
        else pass_cnt++;
        a_clr = 1'b1;
        tick();
        a_clr = 1'b0;
    endtask

    task automatic test_full_push_pop();
        for (int i = 1; i <= 4; i++) a_push(32'(i));
        {a_A, a_Q} = 32'h6;
        a_done = 1'b1;
        a_ready = 1'b1;
        tick();
        a_done = 1'b0;
        a_ready = 1'b0;
        total++;
        if (a_count !== 3'd4 || a_ovf !== 1'b0)
            $display("FAIL full_pp got c=%0d o=%b want 4 0", a_count, a_ovf);
        else pass_cnt++;
        a_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            logic [31:0] exp;
            exp = (i == 3) ? 32'd6 : 32'(i + 2);
            total++;
            if (a_prod !== exp)
                $display("FAIL full_pp_drain%0d got %h want %h", i, a_prod, exp);
            else pass_cnt++;
            tick();
        end
        a_ready = 1'b0;
    endtask

    task automatic test_wrap();
        for (int k = 0; k < 10; k++) begin
            {b_A, b_Q} = 32'(10 + k);
            b_done = 1'b1;
            tick();
            b_done = 1'b0;
            total++;
            if (b_prod !== 32'(10 + k) || b_count !== 2'd1)
                $display("FAIL wrap%0d got %h c=%0d want %h 1", k, b_prod, b_count, 32'(10 + k));
            else pass_cnt++;
            b_ready = 1'b1;
            tick();
            b_ready = 1'b0;
        end
        total++;
        if (b_empty !== 1'b1 || b_ovf !== 1'b0)
            $display("FAIL wrap_end got e=%b o=%b want 1 0", b_empty, b_ovf);
        else pass_cnt++;
    endtask

    task automatic test_ovf_clear();
        for (int i = 1; i <= 4; i++) a_push(32'(i));
        {a_A, a_Q} = 32'h9;
        a_done = 1'b1;
        a_clr = 1'b1;
        tick();
        a_done = 1'b0;
        total++;
        if (a_ovf !== 1'b1 || a_count !== 3'd4)
            $display("FAIL clr_prio got o=%b c=%0d want 1 4", a_ovf, a_count);
        else pass_cnt++;
        tick();
        a_clr = 1'b0;
        total++;
        if (a_ovf !== 1'b0)
            $display("FAIL clr_ovf got %b want 0", a_ovf);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        a_push(32'h9);
        a_ready = 1'b1;
        tick();
        a_ready = 1'b0;
        total++;
        if (a_count !== 3'd3 || a_ovf !== 1'b1)
            $display("FAIL mid_setup got c=%0d o=%b want 3 1", a_count, a_ovf);
        else pass_cnt++;
        #2 rst = 1'b1;
        #1;
        total++;
        if (a_count !== 3'd0 || a_empty !== 1'b1 || a_valid !== 1'b0 || a_ovf !== 1'b0)
            $display("FAIL mid_reset got c=%0d e=%b v=%b o=%b want 0 1 0 0",
                     a_count, a_empty, a_valid, a_ovf);
        else pass_cnt++;
        #1 rst = 1'b0;
        tick();
        a_push(32'h7);
        total++;
        if (a_prod !== 32'h7 || a_count !== 3'd1)
            $display("FAIL mid_first got %h c=%0d want 00000007 1", a_prod, a_count);
        else pass_cnt++;
    endtask

    initial begin
        #1;
        test_reset();
        test_single();
        test_fill_overflow();
        test_full_push_pop();
        test_wrap();
        test_ovf_clear();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
